// File: rtl/parity_sched.sv
// Round-robin scheduler sharing one masked-XOR parity unit among N_REQ requesters.
// Three-state FSM (IDLE -> CALC -> OUT): accept, evaluate, then hold the tagged result until taken.
module parity_sched #(
  parameter int              N_REQ = 4,
  parameter int              WIDTH = 7,
  parameter logic [WIDTH-1:0] MASK = 7'h6F
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*WIDTH-1:0]     req_data,
  output logic [N_REQ-1:0]           req_ready,
  input  logic                       cfg_we,
  input  logic [WIDTH-1:0]           cfg_mask,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic                       res_parity,
  output logic [$clog2(N_REQ)-1:0]   res_id,
  output logic                       busy
);

  localparam int ID_W = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] last_q, id_q, grant, cand;
  logic [WIDTH-1:0] op_q, mask_q;
  logic            any_valid;
  int              idx;
  logic [WIDTH-1:0] data_arr [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign data_arr[k] = req_data[k*WIDTH +: WIDTH];
  end

  // Search starts one past the last winner and wraps, so every requester is served in turn.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    grant     = last_q;
    any_valid = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = int'(last_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = ID_W'(idx);
      if (!any_valid && req_valid[cand]) begin
        any_valid = 1'b1;
        grant     = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == IDLE && any_valid) req_ready[grant] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_valid) state_d = CALC;
      CALC:    state_d = OUT;
      OUT:     if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset is synchronous -- rst_n is sampled at the edge and kept out of the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= IDLE;
      last_q     <= ID_W'(N_REQ - 1);
      id_q       <= '0;
      op_q       <= '0;
      mask_q     <= MASK;
      res_valid  <= 1'b0;
      res_parity <= 1'b0;
      res_id     <= '0;
    end else begin
      state_q <= state_d;
      if (cfg_we) mask_q <= cfg_mask;
      case (state_q)
        IDLE: if (any_valid) begin
          op_q   <= data_arr[grant];
          id_q   <= grant;
          last_q <= grant;
        end
        // mask_q here is the pre-edge value, so a same-cycle cfg_we only affects later operations.
        CALC: begin
          res_parity <= ^(op_q & mask_q);
          res_id     <= id_q;
          res_valid  <= 1'b1;
        end
        OUT:  if (res_ready) res_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_parity_sched.sv
// Directed bench for parity_sched: stimulus pushes expected results into a scoreboard,
// independent monitors check grants, result latency and result contents.
`timescale 1ns/1ps
module tb_parity_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [27:0] req_data;
  logic [3:0]  req_ready;
  logic        cfg_we;
  logic [6:0]  cfg_mask;
  logic        res_valid;
  logic        res_ready;
  logic        res_parity;
  logic [1:0]  res_id;
  logic        busy;

  parity_sched #(.N_REQ(4), .WIDTH(7), .MASK(7'h6F)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .cfg_we(cfg_we), .cfg_mask(cfg_mask),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_parity(res_parity), .res_id(res_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] id;
    logic       par;
  } exp_t;

  exp_t sb_q[$];
  int   acc_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Grant monitor: any grant must be one-hot and only while idle.
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1 && req_ready !== 4'b0000) begin
      check("grant_onehot", 32'($onehot(req_ready)), 1);
      check("grant_idle", busy, 0);
      acc_q.push_back(cyc);
    end
  end

  // Result monitor: latency on each rising res_valid, contents on each handshake.
  initial begin : result_mon
    logic prev_v;
    int   a;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (res_valid && !prev_v) begin
        check("latency_has_accept", acc_q.size() != 0, 1);
        if (acc_q.size() != 0) begin
          a = acc_q.pop_front();
          check("latency", cyc - a, 2);
        end
      end
      prev_v = res_valid;
      if (res_valid && res_ready) begin
        check("result_expected", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("res_id", res_id, e.id);
          check("res_parity", res_parity, e.par);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(int k, logic p);
    exp_t e;
    e.id  = 2'(k);
    e.par = p;
    sb_q.push_back(e);
  endtask

  task automatic wait_ready(int k);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[k] && n < 50);
    check("ready_wait", req_ready[k], 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || sb_q.size() != 0) && n < 50);
    check("idle_wait", busy, 0);
  endtask

  task automatic send(int k, logic [6:0] d, logic exp_par, bit push);
    @(posedge clk); #1;
    req_data[k*7 +: 7] = d;
    req_valid[k] = 1'b1;
    if (push) push_exp(k, exp_par);
    wait_ready(k);
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    acc_q.delete();
  endtask

  initial begin
    int exp_g[6];
    int last_c;
    int n;
    exp_g = '{0, 1, 2, 3, 0, 1};
    last_c = 0;
    rst_n = 1'b0; req_valid = 4'hF; req_data = '0;
    cfg_we = 1'b0; cfg_mask = '0; res_ready = 1'b1;

    // Reset state, with requests pending to show req_ready is forced low.
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_parity", res_parity, 0);
    check("rst_res_id", res_id, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; req_valid = 4'h0;
    acc_q.delete();

    // Basic parity with default mask 7'h6F.
    send(0, 7'h01, 1'b1, 1'b1);
    send(0, 7'h10, 1'b0, 1'b1);
    send(0, 7'h7F, 1'b0, 1'b1);
    wait_idle();

    // Round-robin with all requesters continuously valid.
    do_reset();
    push_exp(0, 1'b1); push_exp(1, 1'b0); push_exp(2, 1'b1);
    push_exp(3, 1'b0); push_exp(0, 1'b1); push_exp(1, 1'b0);
    @(posedge clk); #1;
    req_data = {7'h10, 7'h07, 7'h03, 7'h01};
    req_valid = 4'hF;
    for (int g = 0; g < 6; g++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (req_ready == 4'b0000 && n < 20);
      check("rr_grant", req_ready, 32'(1) << exp_g[g]);
      if (g > 0) check("rr_spacing", cyc - last_c, 3);
      last_c = cyc;
      if (g < 5) @(posedge clk);
    end
    @(posedge clk); #1;
    req_valid = 4'h0;
    wait_idle();

    // Backpressure: result held for 5 cycles while req1 waits.
    res_ready = 1'b0;
    send(0, 7'h01, 1'b1, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!res_valid && n < 10);
    @(posedge clk); #1;
    req_data[7 +: 7] = 7'h03;
    req_valid[1] = 1'b1;
    push_exp(1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", res_valid, 1);
      check("bp_parity", res_parity, 1);
      check("bp_id", res_id, 0);
      check("bp_busy", busy, 1);
      check("bp_req_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_valid_drop", res_valid, 0);
    check("bp_next_grant", req_ready, 4'b0010);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_idle();

    // Configuration: full mask, then a write landing during CALC.
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_mask = 7'h7F;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    send(0, 7'h10, 1'b1, 1'b1);
    wait_idle();
    send(0, 7'h01, 1'b1, 1'b1);
    cfg_we = 1'b1; cfg_mask = 7'h00;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    wait_idle();
    send(0, 7'h01, 1'b0, 1'b1);
    wait_idle();

    // Reset during CALC of a req1 operand: no result, mask and priority restored.
    send(1, 7'h10, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    acc_q.delete();
    @(negedge clk);
    check("mid_rst_parity", res_parity, 0);
    check("mid_rst_id", res_id, 0);
    check("mid_rst_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      check("mid_rst_no_valid", res_valid, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    req_data[0 +: 7]  = 7'h01;
    req_data[14 +: 7] = 7'h10;
    req_valid = 4'b0101;
    push_exp(0, 1'b1);
    push_exp(2, 1'b0);
    @(negedge clk);
    check("post_rst_grant0", req_ready, 4'b0001);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_ready(2);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    wait_idle();

    // req_ready forced low while rst_n is low, even in IDLE with requests.
    @(posedge clk); #1;
    req_valid = 4'hF;
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_forces_ready", req_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    req_valid = 4'h0;
    acc_q.delete();
    repeat (3) @(negedge clk);

    check("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/parity_sched.md
# parity_sched

Round-robin scheduler that shares a single masked-XOR parity unit among `N_REQ` requesters. It accepts one operand at a time through per-requester valid/ready handshakes and computes the parity of the operand bits selected by a runtime-configurable mask. It returns the result, tagged with the requester index, through a valid/ready result port. It sits in front of the parity datapath so that several producers can use one parity evaluator without contention.

## Interface

Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `WIDTH`, 7: operand width in bits.
- `MASK`, 7'h6F: reset value of the mask register. Bit i = 1 means operand bit i contributes to parity. The default excludes bit 4.

Ports:
- `clk`  in  1  — single clock; everything is rising-edge.
- `rst_n`  in  1  — synchronous, active-low reset.
- `req_valid`  in  N_REQ  — bit k: requester k presents an operand.
- `req_data`  in  N_REQ*WIDTH  — operand k is at bits [k*WIDTH +: WIDTH].
- `req_ready`  out  N_REQ  — one-hot or zero; bit k: operand k is accepted this cycle.
- `cfg_we`  in  1  — load `cfg_mask` into the mask register at the next edge.
- `cfg_mask`  in  WIDTH  — new mask value.
- `res_valid`  out  1  — result is available.
- `res_ready`  in  1  — consumer accepts the result.
- `res_parity`  out  1  — XOR-reduction of (operand AND mask).
- `res_id`  out  clog2(N_REQ)  — index of the requester that owns the result.
- `busy`  out  1  — high whenever the state is not IDLE.

## Operation

The block is a three-state FSM: IDLE, CALC, OUT.

**IDLE**
- Arbitration is combinational over `req_valid`. The search starts at `last+1` and wraps modulo `N_REQ`; `last` is the previously granted index.
- If any request is valid, raise `req_ready[g]` for the winner g only. At the edge, capture `req_data[g]` into the operand register and g into the id register, set `last`=g, and go to CALC.
- If no request is valid, stay in IDLE and keep `req_ready` at 0.

**CALC**
- `req_ready` is 0.
- At the edge, register `res_parity` = ^(op & mask_reg), using the mask value held during this cycle.
- Register `res_id` from the id register.
- Go to OUT.

**OUT**
- `res_valid`=1. `res_parity` and `res_id` hold stable.
- When `res_ready`=1 at an edge, go to IDLE; `res_valid` is 0 in the following cycle.
- If `res_ready` stays low, remain in OUT indefinitely with no new acceptance.

**Mask register**
- Updated on any edge where `cfg_we`=1, in any state.
- If `cfg_we` and CALC occur in the same cycle, the parity uses the old mask; the new mask applies from the next operation.

**Reset** (`rst_n`=0 at an edge, in any state, including mid-operation)
- State goes to IDLE.
- `res_valid`=0, `res_parity`=0, `res_id`=0.
- Mask register = `MASK`.
- `last`=`N_REQ`-1, so requester 0 has top priority after reset.
- Operand and id registers go to 0.
- `req_ready` is forced to 0 in any cycle where `rst_n`=0.
- An operand in flight is discarded with no result.

**Other rules**
- `req_valid` deasserted by a requester that was not granted has no effect.
- Data from non-granted requesters is ignored.

## Timing

- Handshake acceptance occurs at edge E0, where `req_valid[g]` and `req_ready[g]` are both 1.
- Parity is registered at E1, and `res_valid` is high in the cycle after E1. Latency is 2 cycles from acceptance to result.
- Earliest next acceptance is the cycle after the result handshake. Peak throughput is one operation per 3 cycles.
- `req_ready` depends combinationally on `req_valid`, state, and `rst_n`. All other outputs are registered.
- `busy` is 1 in CALC and OUT.

## Test plan

- **Basic parity.** After reset, hold `res_ready`=1 and send req0 operands 7'h01, 7'h10 and 7'h7F.
  - Required `res_parity`: 1, 0, 0 respectively (bit 4 is masked; 7'h7F gives six ones).
  - `res_id`=0 each time; `res_valid` rises 2 cycles after each acceptance.
- **Round-robin.** After reset, hold all 4 `req_valid` high continuously.
  - Grant sequence is 0,1,2,3,0,1.
  - `req_ready` is one-hot in IDLE cycles only, with 3-cycle spacing.
- **Backpressure.** Drive the result with `res_ready`=0 for 5 cycles.
  - `res_valid`, `res_parity` and `res_id` stay stable; `busy`=1; `req_ready`=0 throughout.
  - After `res_ready`=1 for one edge, `res_valid`=0 and the next grant follows.
- **Configuration.** Write `cfg_mask`=7'h7F, then send 7'h10 → parity 1.
  - Issue `cfg_we` with mask 7'h00 during CALC of operand 7'h01 → that result is 1 (old mask). The next 7'h01 → 0.
- **Reset mid-operation.** Assert `rst_n`=0 for one edge while in CALC.
  - No `res_valid` is produced; mask returns to 7'h6F; outputs are 0.
  - A subsequent request from requesters 2 and 0 together is granted to 0 first.
